mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier feeding the synreg product register via clk_en/sclr_n.
// Optional `MULT_SEQ_ZERO_SKIP_EN: a zero operand at start jumps straight to DONE.
module mult_seq_ctrl #(
    parameter bit ERR_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product,
    output logic        reg_clk_en,
    output logic        reg_sclr_n,
    output logic        done,
    output logic        busy,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;

    logic [3:0]  a_nib, b_nib;
    logic [3:0]  shamt;
    logic [7:0]  nib_prod;
    logic [15:0] pp_term;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Nibble pair and weight of the partial product for the current PP state
    always_comb begin
        a_nib = a_q[3:0];
        b_nib = b_q[3:0];
        shamt = 4'd0;
        case (state_q)
            S_PP1: begin a_nib = a_q[7:4]; shamt = 4'd4; end
            S_PP2: begin b_nib = b_q[7:4]; shamt = 4'd4; end
            S_PP3: begin a_nib = a_q[7:4]; b_nib = b_q[7:4]; shamt = 4'd8; end
            default: ;
        endcase
        nib_prod = {4'h0, a_nib} * {4'h0, b_nib};
        pp_term  = {8'h00, nib_prod} << shamt;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = dataa;
                    b_d   = datab;
                    acc_d = '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    state_d = ((dataa == 8'h00) || (datab == 8'h00)) ? S_DONE : S_PP0;
`else
                    state_d = S_PP0;
`endif
                end
            end
            S_PP0, S_PP1, S_PP2, S_PP3: begin
                if (start) begin
                    state_d = S_ERR;
                end else begin
                    acc_d = acc_q + pp_term;
                    case (state_q)
                        S_PP0:   state_d = S_PP1;
                        S_PP1:   state_d = S_PP2;
                        S_PP2:   state_d = S_PP3;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = start ? S_ERR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done       = 1'b0;
        busy       = 1'b0;
        reg_clk_en = 1'b0;
        reg_sclr_n = 1'b1;
        case (state_q)
            S_PP0, S_PP1, S_PP2, S_PP3: busy = 1'b1;
            S_DONE: begin
                done       = 1'b1;
                reg_clk_en = 1'b1;
            end
            S_ERR: begin
                reg_clk_en = ERR_CLR;
                reg_sclr_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign state_out = state_q;
    assign product   = acc_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural synreg load/clear register downstream.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa, datab;
    logic [15:0] product;
    logic        reg_clk_en, reg_sclr_n, done, busy;
    logic [2:0]  state_out;
    logic [15:0] synreg_q;

    int errors = 0;
    int checks = 0;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 5;
    localparam int ZBUSY = 4;
`endif

    mult_seq_ctrl #(.ERR_CLR(1'b1)) dut (
        .clk        (clk),
        .reset_a    (reset_a),
        .start      (start),
        .dataa      (dataa),
        .datab      (datab),
        .product    (product),
        .reg_clk_en (reg_clk_en),
        .reg_sclr_n (reg_sclr_n),
        .done       (done),
        .busy       (busy),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset_a) begin
        if (reset_a)         synreg_q <= '0;
        else if (reg_clk_en) synreg_q <= reg_sclr_n ? product : 16'h0000;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
        int          lat;
        int          busyc;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            output logic [15:0] p, output int lat, output int busyc);
        dataa = a;
        datab = b;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        busyc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            step();
            lat++;
            busyc += busy ? 1 : 0;
        end
        p = product;
    endtask

    initial begin
        logic [15:0] p;
        int lat, busyc, dones, cyc;
        logic [2:0] seq_exp [6];

        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 5, 4};
        vecs[1] = '{8'hA5, 8'h3C, 16'h26AC, 5, 4};
        vecs[2] = '{8'h03, 8'h05, 16'h000F, 5, 4};
        vecs[3] = '{8'h12, 8'h34, 16'h03A8, 5, 4};
        vecs[4] = '{8'h80, 8'h02, 16'h0100, 5, 4};
        vecs[5] = '{8'h01, 8'hFF, 16'h00FF, 5, 4};
        vecs[6] = '{8'h00, 8'h77, 16'h0000, ZLAT, ZBUSY};
        seq_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

        reset_a = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        #2;
        chk("rst_state", state_out, 3'd0);
        chk("rst_product", product, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clk_en", reg_clk_en, 1'b0);
        chk("rst_sclr_n", reg_sclr_n, 1'b1);
        step();
        reset_a = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_mult(vecs[i].a, vecs[i].b, p, lat, busyc);
            chk($sformatf("v%0d_product", i), p, vecs[i].exp_p);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), busyc, vecs[i].busyc);
            chk($sformatf("v%0d_clk_en", i), reg_clk_en, 1'b1);
            chk($sformatf("v%0d_state_done", i), state_out, 3'd5);
            step();
            chk($sformatf("v%0d_synreg", i), synreg_q, vecs[i].exp_p);
            chk($sformatf("v%0d_done_low", i), done, 1'b0);
            chk($sformatf("v%0d_clk_en_low", i), reg_clk_en, 1'b0);
            chk($sformatf("v%0d_state_idle", i), state_out, 3'd0);
        end

        // State code sequence for A5*3C
        chk("seq_idle_before", state_out, 3'd0);
        dataa = 8'hA5;
        datab = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seq_state%0d", i), state_out, seq_exp[i]);
            if (i == 4) chk("seq_product", product, 16'h26AC);
            step();
        end

        // Reset asserted in PP2 aborts immediately
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_state_pp2", state_out, 3'd3);
        chk("mid_product_pp2", product, 16'h0048);
        reset_a = 1'b1;
        #1;
        chk("mid_rst_state", state_out, 3'd0);
        chk("mid_rst_product", product, 16'h0000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_clk_en", reg_clk_en, 1'b0);
        chk("mid_rst_sclr_n", reg_sclr_n, 1'b1);
        step();
        reset_a = 1'b0;
        step();
        chk("post_rst_state", state_out, 3'd0);
        run_mult(8'd3, 8'd5, p, lat, busyc);
        chk("post_rst_product", p, 16'd15);
        chk("post_rst_latency", lat, 5);
        step();
        chk("post_rst_synreg", synreg_q, 16'd15);

        // start reasserted in PP1 -> ERR, clears downstream register
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("err_pp1", state_out, 3'd2);
        start = 1'b1;
        dones = 0;
        step();
        chk("err_state", state_out, 3'd6);
        chk("err_sclr_n", reg_sclr_n, 1'b0);
        chk("err_clk_en", reg_clk_en, 1'b1);
        chk("err_product_frozen", product, 16'h0008);
        for (int i = 0; i < 3; i++) begin
            dones += done ? 1 : 0;
            step();
            chk($sformatf("err_hold%0d", i), state_out, 3'd6);
        end
        chk("err_synreg_cleared", synreg_q, 16'h0000);
        chk("err_no_done", dones + (done ? 1 : 0), 0);
        start = 1'b0;
        step();
        chk("err_exit_idle", state_out, 3'd0);

        // start seen in DONE is ignored; operands changed mid-run are not used
        dataa = 8'h0F;
        datab = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        dataa = 8'hFF;
        datab = 8'hFF;
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        chk("bb_first_product", product, 16'h00E1);
        chk("bb_first_latency", lat, 5);
        start = 1'b1;
        step();
        chk("bb_done_to_idle", state_out, 3'd0);
        cyc = 1;
        step();
        cyc++;
        chk("bb_accept", state_out, 3'd1);
        start = 1'b0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
        chk("bb_period", cyc, 6);
        chk("bb_second_product", product, 16'hFE01);
        step();
        chk("bb_synreg", synreg_q, 16'hFE01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
